rom_stream_accum: RTL and testbench

ROM_STREAM_ACCUM -- requirements
Module: rom_stream_accum

---
 rtl/rom_stream_accum.sv | 87 ++++++++
 tb/tb_rom_stream_accum.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/rom_stream_accum.sv
// rom_stream_accum: per-frame sum/count/overflow of a ROM word stream, reported once per done_in.
// Min/max tracking is built only when ROM_STREAM_MINMAX_EN is defined; otherwise min_out/max_out are 0.
module rom_stream_accum #(
  parameter int DATA_W    = 16,
  parameter int MAX_WORDS = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              done_in,
  output logic [DATA_W+6:0] sum_out,
  output logic [DATA_W-1:0] min_out,
  output logic [DATA_W-1:0] max_out,
  output logic [6:0]        count_out,
  output logic              overflow,
  output logic              result_valid,
  output logic              busy
);
  localparam int SW = DATA_W + 7;
  localparam logic [1:0] IDLE = 2'd0, ACC = 2'd1, REPORT = 2'd2;
  logic [1:0]    state_q, state_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [6:0]    cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          first, empty, take;
  // first word of a frame, empty frame, and an accepted in-frame word
  assign first = state_q == IDLE && valid_in;
  assign empty = state_q == IDLE && !valid_in && done_in;
  assign take  = state_q == ACC && valid_in && cnt_q < 7'(MAX_WORDS);
  assign busy  = state_q == ACC;
  always_comb begin
    state_d = state_q == IDLE ? (valid_in ? ACC : done_in ? REPORT : IDLE)
            : state_q == ACC  ? (done_in ? REPORT : ACC) : IDLE;
    sum_d   = first ? SW'(data_in) : empty ? '0 : take ? sum_q + SW'(data_in) : sum_q;
    cnt_d   = first ? 7'd1 : empty ? 7'd0 : take ? cnt_q + 7'd1 : cnt_q;
    ovf_d   = (first || empty) ? 1'b0 : ovf_q || (state_q == ACC && valid_in && !take);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      sum_q        <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      sum_out      <= '0;
      count_out    <= '0;
      overflow     <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      state_q      <= state_d;
      sum_q        <= sum_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      result_valid <= state_q == REPORT;
      if (state_q == REPORT) begin
        sum_out   <= sum_q;
        count_out <= cnt_q;
        overflow  <= ovf_q;
      end
    end
  end
`ifdef ROM_STREAM_MINMAX_EN
  logic [DATA_W-1:0] min_q, min_d, max_q, max_d;
  always_comb begin
    min_d = first ? data_in : empty ? '1 : (take && data_in < min_q) ? data_in : min_q;
    max_d = first ? data_in : empty ? '0 : (take && data_in > max_q) ? data_in : max_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      min_q   <= '0;
      max_q   <= '0;
      min_out <= '0;
      max_out <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
      if (state_q == REPORT) begin
        min_out <= min_q;
        max_out <= max_q;
      end
    end
  end
`else
  assign min_out = '0;
  assign max_out = '0;
`endif
endmodule

// File: tb/tb_rom_stream_accum.sv
// tb_rom_stream_accum: directed frames against hand-computed sums, counts, min/max and pulse timing.
module tb_rom_stream_accum;
`ifdef ROM_STREAM_MINMAX_EN
  localparam bit MM = 1'b1;
`else
  localparam bit MM = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_in = 1'b0;
  logic [15:0] data_in = '0;
  logic        done_in = 1'b0;
  logic [22:0] sum_out;
  logic [15:0] min_out, max_out;
  logic [6:0]  count_out;
  logic        overflow, result_valid, busy;
  int          total = 0;
  int          bad = 0;
  int          rv_cnt = 0;
  int          rv_mark;

  rom_stream_accum #(.DATA_W(16), .MAX_WORDS(100)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in), .done_in(done_in),
    .sum_out(sum_out), .min_out(min_out), .max_out(max_out), .count_out(count_out),
    .overflow(overflow), .result_valid(result_valid), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (result_valid) rv_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // drives n words v0+i*inc; done_in either with the last word or one cycle later
  task automatic run_frame(input int n, input int v0, input int inc, input bit late_done);
    for (int i = 0; i < n; i++) begin
      valid_in = 1'b1;
      data_in  = 16'(v0 + i * inc);
      done_in  = !late_done && i == n - 1;
      tick;
      if (i == 0) chk("busy_in_frame", busy, 1);
    end
    if (late_done) begin
      valid_in = 1'b0;
      done_in  = 1'b1;
      tick;
    end
    valid_in = 1'b0;
    done_in  = 1'b0;
  endtask

  // called one cycle after the done_in cycle: pulse must land on the following cycle only
  task automatic expect_result(input string tag, input int s, input int c, input int mn, input int mx, input int ov);
    chk({tag, "_rv_early"}, result_valid, 0);
    tick;
    chk({tag, "_rv"}, result_valid, 1);
    chk({tag, "_sum"}, sum_out, s);
    chk({tag, "_count"}, count_out, c);
    chk({tag, "_min"}, min_out, MM ? mn : 0);
    chk({tag, "_max"}, max_out, MM ? mx : 0);
    chk({tag, "_ovf"}, overflow, ov);
    tick;
    chk({tag, "_rv_late"}, result_valid, 0);
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  initial begin
    #12;
    chk("rst_sum", sum_out, 0);
    chk("rst_count", count_out, 0);
    chk("rst_min", min_out, 0);
    chk("rst_max", max_out, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    tick;
    tick;
    chk("idle_busy", busy, 0);

    run_frame(100, 0, 1, 1'b1);
    expect_result("ramp", 4950, 100, 0, 99, 0);
    tick;
    tick;
    chk("hold_sum", sum_out, 4950);
    chk("hold_count", count_out, 100);

    run_frame(100, 16'hFFFF, 0, 1'b1);
    expect_result("ones", 6553500, 100, 16'hFFFF, 16'hFFFF, 0);

    run_frame(105, 1, 0, 1'b1);
    expect_result("ovf", 100, 100, 1, 1, 1);

    done_in = 1'b1;
    tick;
    done_in = 1'b0;
    expect_result("empty", 0, 0, 16'hFFFF, 0, 0);

    // done with the last word, then words offered during REPORT must be dropped
    valid_in = 1'b1; data_in = 16'd5; tick;
    data_in = 16'd2; tick;
    data_in = 16'd9; done_in = 1'b1; tick;
    data_in = 16'd100;
    chk("short_rv_early", result_valid, 0);
    tick;
    valid_in = 1'b0;
    done_in  = 1'b0;
    chk("short_rv", result_valid, 1);
    chk("short_sum", sum_out, 16);
    chk("short_count", count_out, 3);
    chk("short_min", min_out, MM ? 2 : 0);
    chk("short_max", max_out, MM ? 9 : 0);
    chk("report_word_ignored", busy, 0);
    tick;
    chk("short_rv_late", result_valid, 0);

    for (int i = 0; i < 50; i++) begin
      valid_in = 1'b1;
      data_in  = 16'(i);
      tick;
    end
    valid_in = 1'b0;
    rv_mark  = rv_cnt;
    #2 rst = 1'b0;
    #1;
    chk("arst_sum", sum_out, 0);
    chk("arst_count", count_out, 0);
    chk("arst_busy", busy, 0);
    tick;
    tick;
    #3 rst = 1'b1;
    tick;
    tick;
    tick;
    chk("arst_no_pulse", rv_cnt, rv_mark);
    run_frame(100, 0, 1, 1'b1);
    expect_result("after_rst", 4950, 100, 0, 99, 0);
    chk("after_rst_pulses", rv_cnt, rv_mark + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
